multdiv_sequencer: RTL

//  Owns the shared iterative multdiv unit for the X stage. Accepts a mult/div

---
 rtl/multdiv_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/multdiv_sequencer.sv
// Sequencer for the shared iterative multdiv unit in the X stage: latches operands,
// issues one start pulse, stalls until done. Optional BUSY timeout via MDSEQ_TIMEOUT_EN.
module multdiv_sequencer #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned CNT_W          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_is_div,
  input  logic [DATA_W-1:0] req_opA,
  input  logic [DATA_W-1:0] req_opB,
  input  logic              flush,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  output logic [DATA_W-1:0] md_opA,
  output logic [DATA_W-1:0] md_opB,
  input  logic              md_resultRDY,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] result,
  output logic              exception,
  output logic [DATA_W-1:0] err_code,
  output logic [CNT_W-1:0]  busy_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    BUSY  = 2'b10,
    DONE  = 2'b11
  } state_t;

`ifdef MDSEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam int unsigned       CNT_MAX     = (32'd1 << CNT_W) - 32'd1;
  // A timeout beyond the saturating counter range clamps to the counter maximum.
  localparam logic [CNT_W-1:0]  TIMEOUT_CNT = (TIMEOUT_CYCLES > CNT_MAX) ? '1 : CNT_W'(TIMEOUT_CYCLES);
  localparam logic [DATA_W-1:0] ERR_MULT    = DATA_W'(4);
  localparam logic [DATA_W-1:0] ERR_DIV     = DATA_W'(5);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  op_a_q, op_b_q;
  logic               is_div_q;
  logic [CNT_W-1:0]   cnt_q, cnt_inc;
  logic               latch_en, cnt_clr, cnt_en;
  logic               capture, abort, timeout_hit, exc_next;

  assign md_opA  = op_a_q;
  assign md_opB  = op_b_q;
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  // cnt_inc is the BUSY cycle count including the current cycle.
  always_comb begin
    timeout_hit = TIMEOUT_EN && (cnt_inc >= TIMEOUT_CNT);
  end

  always_comb begin
    state_d      = state_q;
    stall        = 1'b0;
    ctrl_MULT    = 1'b0;
    ctrl_DIV     = 1'b0;
    result_valid = 1'b0;
    latch_en     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    capture      = 1'b0;
    abort        = 1'b0;
    exc_next     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          stall    = 1'b1;
          latch_en = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        stall     = 1'b1;
        ctrl_MULT = !is_div_q;
        ctrl_DIV  = is_div_q;
        cnt_clr   = 1'b1;
        state_d   = flush ? IDLE : BUSY;
      end
      BUSY: begin
        stall  = 1'b1;
        cnt_en = 1'b1;
        // flush beats completion; completion beats timeout.
        if (flush) begin
          state_d = IDLE;
        end else if (md_resultRDY) begin
          capture  = 1'b1;
          exc_next = md_exception;
          state_d  = DONE;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          exc_next = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        result_valid = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      is_div_q    <= 1'b0;
      cnt_q       <= '0;
      result      <= '0;
      exception   <= 1'b0;
      err_code    <= '0;
      busy_cycles <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        op_a_q   <= req_opA;
        op_b_q   <= req_opB;
        is_div_q <= req_is_div;
      end
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (cnt_en) begin
        cnt_q <= cnt_inc;
      end
      if (capture || abort) begin
        busy_cycles <= cnt_inc;
        exception   <= exc_next;
        result      <= exc_next ? '0 : md_result;
        err_code    <= exc_next ? (is_div_q ? ERR_DIV : ERR_MULT) : '0;
      end
    end
  end

`ifndef SYNTHESIS
  a_onehot_start: assert property (@(posedge clock) disable iff (reset)
    !(ctrl_MULT && ctrl_DIV));
  a_single_pulse: assert property (@(posedge clock) disable iff (reset)
    (ctrl_MULT || ctrl_DIV) |=> !(ctrl_MULT || ctrl_DIV));
`endif

endmodule
